// File: rtl/stopwatch_timer_dp_pkg.sv
// Shared time-field definitions for the FND stopwatch: field widths, field limits,
// count direction and the packed time word, plus the per-tick field arithmetic.
package stopwatch_timer_dp_pkg;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned CS_W   = 7;

    localparam logic [CS_W-1:0]  CS_MAX = 7'd99;
    localparam logic [SEC_W-1:0] SM_MAX = 6'd59;

    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } mode_e;

    // Packing order matches the 24-bit port word {hour, min, sec, cs}.
    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [CS_W-1:0]   cs;
    } time_t;

    // Clamp every field of a preset to its largest legal value.
    function automatic time_t time_sat(input time_t t, input logic [HOUR_W-1:0] hour_max);
        time_t r;
        r      = t;
        r.cs   = (t.cs   > CS_MAX)   ? CS_MAX   : t.cs;
        r.sec  = (t.sec  > SM_MAX)   ? SM_MAX   : t.sec;
        r.min  = (t.min  > SM_MAX)   ? SM_MAX   : t.min;
        r.hour = (t.hour > hour_max) ? hour_max : t.hour;
        return r;
    endfunction

    function automatic logic time_is_max(input time_t t, input logic [HOUR_W-1:0] hour_max);
        return (t.cs == CS_MAX) && (t.sec == SM_MAX) && (t.min == SM_MAX) && (t.hour == hour_max);
    endfunction

    // One centisecond forward; all carries resolve in a single cycle.
    function automatic time_t time_inc(input time_t t, input logic [HOUR_W-1:0] hour_max);
        time_t r;
        r = t;
        if (t.cs != CS_MAX) begin
            r.cs = t.cs + 7'd1;
        end else begin
            r.cs = '0;
            if (t.sec != SM_MAX) begin
                r.sec = t.sec + 6'd1;
            end else begin
                r.sec = '0;
                if (t.min != SM_MAX) begin
                    r.min = t.min + 6'd1;
                end else begin
                    r.min  = '0;
                    r.hour = (t.hour == hour_max) ? '0 : t.hour + 5'd1;
                end
            end
        end
        return r;
    endfunction

    // One centisecond backward; caller guarantees the time is non-zero.
    function automatic time_t time_dec(input time_t t, input logic [HOUR_W-1:0] hour_max);
        time_t r;
        r = t;
        if (t.cs != '0) begin
            r.cs = t.cs - 7'd1;
        end else begin
            r.cs = CS_MAX;
            if (t.sec != '0) begin
                r.sec = t.sec - 6'd1;
            end else begin
                r.sec = SM_MAX;
                if (t.min != '0) begin
                    r.min = t.min - 6'd1;
                end else begin
                    r.min  = SM_MAX;
                    r.hour = (t.hour == '0) ? hour_max : t.hour - 5'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_timer_dp_tick_prescaler.sv
// Base-tick prescaler: counts 0..DIV-1 while enabled and raises a registered
// one-cycle tick after each wrap. When disabled, both the count and a pending
// tick are held so that resuming keeps the original phase.
module tick_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_sclr,
    output logic o_tick
);

    localparam int unsigned     CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count and tick: sync clear wins, otherwise advance only while enabled.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = tick_q;
        if (i_sclr) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (i_en) begin
            tick_d = (cnt_q == LAST);
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Prescaler state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/stopwatch_timer_dp.sv
// Stopwatch / countdown timekeeping datapath: h:m:s.cs counter with up/down
// modes, saturating preset load, lap capture and wrap/done/expired flags.
module stopwatch_timer_dp
    import stopwatch_timer_dp_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned TICK_HZ  = 100,
    parameter int unsigned HOUR_MOD = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_run,
    input  logic        i_clear,
    input  logic        i_mode,
    input  logic        i_load,
    input  logic [23:0] i_preset,
    input  logic        i_lap,
    output logic [23:0] o_time,
    output logic [23:0] o_lap,
    output logic        o_lap_valid,
    output logic        o_wrap,
    output logic        o_done,
    output logic        o_expired
);

    localparam int unsigned       DIV      = CLK_HZ / TICK_HZ;
    localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOUR_MOD - 1);

    time_t time_q, time_d;
    time_t lap_q, lap_d;
    logic  lap_valid_q, lap_valid_d;
    logic  wrap_q, wrap_d;
    logic  done_q, done_d;
    logic  expired_q, expired_d;

    logic  tick;
    mode_e mode;

    assign mode = mode_e'(i_mode);

    // Clear and load both restart the tick phase from zero.
    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_en   (i_run),
        .i_sclr (i_clear | i_load),
        .o_tick (tick)
    );

    // Next time, lap and flag values: clear > load > tick update; lap runs alongside load/tick.
    always_comb begin
        time_d      = time_q;
        lap_d       = lap_q;
        lap_valid_d = 1'b0;
        wrap_d      = 1'b0;
        done_d      = 1'b0;
        expired_d   = expired_q;
        if (i_clear) begin
            time_d    = '0;
            lap_d     = '0;
            expired_d = 1'b0;
        end else begin
            if (i_lap) begin
                lap_d       = time_q;
                lap_valid_d = 1'b1;
            end
            if (i_load) begin
                time_d    = time_sat(time_t'(i_preset), HOUR_MAX);
                expired_d = 1'b0;
            end else if (tick && i_run) begin
                if (mode == MODE_UP) begin
                    time_d = time_inc(time_q, HOUR_MAX);
                    wrap_d = time_is_max(time_q, HOUR_MAX);
                end else if (time_q != '0) begin
                    time_d = time_dec(time_q, HOUR_MAX);
                    if (time_q == time_t'(24'd1)) begin
                        done_d    = 1'b1;
                        expired_d = 1'b1;
                    end
                end
            end
        end
    end

    // Time, lap and flag registers; flags land in the same cycle as the new time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q      <= '0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            time_q      <= time_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            expired_q   <= expired_d;
        end
    end

    assign o_time      = time_q;
    assign o_lap       = lap_q;
    assign o_lap_valid = lap_valid_q;
    assign o_wrap      = wrap_q;
    assign o_done      = done_q;
    assign o_expired   = expired_q;

endmodule

// File: tb/tb_stopwatch_timer_dp.sv
// Self-checking bench for stopwatch_timer_dp. The reference model keeps time as a
// plain centisecond total with modulo arithmetic and packs it only for comparison.
module tb_stopwatch_timer_dp;

    localparam int unsigned CLK_HZ   = 1000;
    localparam int unsigned TICK_HZ  = 100;
    localparam int unsigned HOUR_MOD = 24;
    localparam int unsigned DIV      = CLK_HZ / TICK_HZ;
    localparam int          DAY      = HOUR_MOD * 360000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_run, i_clear, i_mode, i_load, i_lap;
    logic [23:0] i_preset;
    logic [23:0] o_time, o_lap;
    logic        o_lap_valid, o_wrap, o_done, o_expired;
    logic [51:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_time, m_lap, m_phase;
    bit m_lapv, m_wrap, m_done, m_exp, m_pend;

    stopwatch_timer_dp #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .HOUR_MOD (HOUR_MOD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_run       (i_run),
        .i_clear     (i_clear),
        .i_mode      (i_mode),
        .i_load      (i_load),
        .i_preset    (i_preset),
        .i_lap       (i_lap),
        .o_time      (o_time),
        .o_lap       (o_lap),
        .o_lap_valid (o_lap_valid),
        .o_wrap      (o_wrap),
        .o_done      (o_done),
        .o_expired   (o_expired)
    );

    always #5 clk = ~clk;

    assign dut_vec = {o_time, o_lap, o_lap_valid, o_wrap, o_done, o_expired};

    function automatic logic [23:0] pack(input int t);
        int h, m, s, c;
        h = t / 360000;
        m = (t / 6000) % 60;
        s = (t / 100) % 60;
        c = t % 100;
        return {5'(h), 6'(m), 6'(s), 7'(c)};
    endfunction

    function automatic int hms(input int h, input int m, input int s, input int c);
        return h * 360000 + m * 6000 + s * 100 + c;
    endfunction

    function automatic int sat(input logic [23:0] p);
        int h, m, s, c;
        h = int'(p[23:19]);
        m = int'(p[18:13]);
        s = int'(p[12:7]);
        c = int'(p[6:0]);
        if (h > HOUR_MOD - 1) h = HOUR_MOD - 1;
        if (m > 59) m = 59;
        if (s > 59) s = 59;
        if (c > 99) c = 99;
        return hms(h, m, s, c);
    endfunction

    function automatic logic [51:0] exp_vec();
        return {pack(m_time), pack(m_lap), m_lapv, m_wrap, m_done, m_exp};
    endfunction

    task automatic model_reset();
        m_time = 0; m_lap = 0; m_phase = 0;
        m_lapv = 0; m_wrap = 0; m_done = 0; m_exp = 0; m_pend = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        if (i_clear) begin
            model_reset();
            return;
        end
        m_lapv = 0; m_wrap = 0; m_done = 0;
        if (i_lap) begin
            m_lap  = m_time;
            m_lapv = 1;
        end
        if (i_load) begin
            m_time  = sat(i_preset);
            m_exp   = 0;
            m_phase = 0;
            m_pend  = 0;
        end else begin
            if (m_pend && i_run) begin
                if (!i_mode) begin
                    m_time = (m_time + 1) % DAY;
                    if (m_time == 0) m_wrap = 1;
                end else if (m_time > 0) begin
                    m_time = m_time - 1;
                    if (m_time == 0) begin
                        m_done = 1;
                        m_exp  = 1;
                    end
                end
            end
            if (i_run) begin
                m_pend  = (m_phase == DIV - 1);
                m_phase = (m_phase + 1) % DIV;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_run = 0; i_clear = 0; i_mode = 0; i_load = 0; i_lap = 0; i_preset = '0;
        model_reset();
        #12;
        checks++;
        if (o_time !== 24'd0) begin errors++; $display("FAIL reset_time got %h exp %h", o_time, 24'd0); end
        checks++;
        if (o_lap !== 24'd0) begin errors++; $display("FAIL reset_lap got %h exp %h", o_lap, 24'd0); end
        checks++;
        if ({o_lap_valid, o_wrap, o_done, o_expired} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {o_lap_valid, o_wrap, o_done, o_expired});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        i_run = 1'b1;
        repeat (1001) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL run_trace got %h exp %h", dut_vec, exp_vec()); end
        end
        checks++;
        if (o_time !== pack(100)) begin errors++; $display("FAIL one_second got %h exp %h", o_time, pack(100)); end
        checks++;
        if ({o_wrap, o_done, o_expired} !== 3'b0) begin
            errors++; $display("FAIL one_second_flags got %b exp 000", {o_wrap, o_done, o_expired});
        end
    endtask

    task automatic test_wrap();
        int wraps = 0;
        i_mode = 0; i_run = 1; i_load = 1; i_preset = pack(hms(23, 59, 59, 99));
        step();
        i_load = 0;
        checks++;
        if (o_time !== pack(hms(23, 59, 59, 99))) begin errors++; $display("FAIL wrap_load got %h exp %h", o_time, pack(hms(23, 59, 59, 99))); end
        repeat (2 * DIV) begin
            step();
            if (o_wrap) wraps++;
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL wrap_trace got %h exp %h", dut_vec, exp_vec()); end
        end
        checks++;
        if (o_time !== 24'd0) begin errors++; $display("FAIL wrap_time got %h exp %h", o_time, 24'd0); end
        checks++;
        if (wraps != 1) begin errors++; $display("FAIL wrap_pulses got %0d exp 1", wraps); end
    endtask

    task automatic test_countdown();
        int dones = 0;
        i_mode = 1; i_run = 1; i_load = 1; i_preset = pack(100);
        step();
        i_load = 0;
        repeat (100 * DIV + 1 + 20 * DIV) begin
            step();
            if (o_done) dones++;
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL down_trace got %h exp %h", dut_vec, exp_vec()); end
        end
        checks++;
        if (o_time !== 24'd0 || o_expired !== 1'b1) begin
            errors++; $display("FAIL down_end got %h/%b exp 000000/1", o_time, o_expired);
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL down_done_pulses got %0d exp 1", dones); end
        // Loading zero in down mode clears expiry and must not fire done.
        i_load = 1; i_preset = '0;
        step();
        i_load = 0;
        checks++;
        if ({o_done, o_expired} !== 2'b00) begin errors++; $display("FAIL load_zero_flags got %b exp 00", {o_done, o_expired}); end
    endtask

    task automatic test_freeze();
        int n;
        i_clear = 1; step(); i_clear = 0;
        i_mode = 0; i_run = 1;
        repeat (5) step();
        i_run = 0;
        repeat (50) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL freeze_trace got %h exp %h", dut_vec, exp_vec()); end
        end
        i_run = 1;
        n = 0;
        while (o_time == 24'd0 && n < 3 * DIV) begin
            step();
            n++;
        end
        // 5 clocks to finish the tick period, one more for the time update.
        checks++;
        if (n != 6) begin errors++; $display("FAIL resume_phase got %0d exp 6", n); end
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL resume_state got %h exp %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_lap();
        int k = 0;
        i_clear = 1; step(); i_clear = 0;
        i_mode = 0; i_run = 1;
        while (!(m_time == 9 && m_pend) && k < 30 * DIV) begin
            step();
            k++;
        end
        checks++;
        if (k >= 30 * DIV) begin errors++; $display("FAIL lap_setup got timeout exp tick at 9"); end
        i_lap = 1;
        step();
        i_lap = 0;
        checks++;
        if (o_lap !== pack(9)) begin errors++; $display("FAIL lap_value got %h exp %h", o_lap, pack(9)); end
        checks++;
        if (o_time !== pack(10)) begin errors++; $display("FAIL lap_time got %h exp %h", o_time, pack(10)); end
        checks++;
        if (o_lap_valid !== 1'b1) begin errors++; $display("FAIL lap_valid got %b exp 1", o_lap_valid); end
        step();
        checks++;
        if (o_lap_valid !== 1'b0) begin errors++; $display("FAIL lap_valid_pulse got %b exp 0", o_lap_valid); end
    endtask

    task automatic test_load_clear_rst();
        i_run = 1; i_mode = 0; i_load = 1; i_preset = 24'hFF_FFFF;
        step();
        i_load = 0;
        checks++;
        if (o_time !== {5'd23, 6'd59, 6'd59, 7'd99}) begin
            errors++; $display("FAIL load_sat got %h exp %h", o_time, {5'd23, 6'd59, 6'd59, 7'd99});
        end
        i_lap = 1; repeat (37) step(); i_lap = 0;
        i_clear = 1; step(); i_clear = 0;
        checks++;
        if (dut_vec !== 52'd0) begin errors++; $display("FAIL clear_all got %h exp 0", dut_vec); end
        i_lap = 1; repeat (23) step(); i_lap = 0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== 52'd0) begin errors++; $display("FAIL async_rst got %h exp 0", dut_vec); end
        @(negedge clk);
        rst = 1'b0;
        repeat (15) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL post_rst_trace got %h exp %h", dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 199));
            i_clear = (r < 2);
            i_load  = (r >= 2 && r < 8);
            case ($urandom_range(0, 5))
                0: i_preset = $urandom;
                1: i_preset = pack(DAY - 1 - int'($urandom_range(0, 3)));
                2: i_preset = pack(int'($urandom_range(1, 3)));
                3: i_preset = pack(hms(int'($urandom_range(0, 23)), 59, 59, 99));
                4: i_preset = pack(hms(0, int'($urandom_range(0, 59)), 0, 0));
                default: i_preset = pack(int'($urandom_range(0, DAY - 1)));
            endcase
            i_lap = ($urandom_range(0, 7) == 0);
            i_run = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 63) == 0) i_mode = ~i_mode;
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_trace got %h exp %h", dut_vec, exp_vec()); end
        end
        i_clear = 0; i_load = 0; i_lap = 0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_countdown();
        test_freeze();
        test_lap();
        test_load_clear_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
